// File: rtl/fetch_queue_if.sv
// Bus bundle between fetch_queue, the instruction memory and the FD stage.
// DEPTH must match the fetch_queue instance so that count has the right width.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   address_imem;
  logic [31:0]   q_imem;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output address_imem, out_valid, out_pc, out_instr, count,
    input  q_imem, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  address_imem, out_valid, out_pc, out_instr, count,
    output q_imem, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: drives imem, absorbs its 1-cycle latency, buffers DEPTH {pc, instr} pairs.
// Optional j/jal predecode redirect is enabled with `define FETCHQ_JUMP_PREDECODE_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic           clock,
  input logic           reset,
  fetch_queue_if.master fq
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CW1 = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   tag_q, tag_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   entry_pc_q    [DEPTH];
  logic [31:0]   entry_instr_q [DEPTH];

  logic          valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic          jump_hit;
  logic [CW1-1:0] credits;

`ifdef FETCHQ_JUMP_PREDECODE_EN
  function automatic logic is_jump(input logic [31:0] instr);
    return (instr[31:27] == 5'b00001) || (instr[31:27] == 5'b00011);
  endfunction
`endif

  assign valid = (count_q != '0);

  always_comb begin
    pop     = valid & fq.out_ready;
    push    = inflight_q & ~fq.redirect;
    // Outstanding request holds a slot, so it counts against free space.
    credits = CW1'(count_q) + CW1'(inflight_q) - CW1'(pop);
    issue   = ~fq.redirect & (credits < CW1'(DEPTH));
`ifdef FETCHQ_JUMP_PREDECODE_EN
    jump_hit = push & is_jump(fq.q_imem);
`else
    jump_hit = 1'b0;
`endif
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (fq.redirect) begin
      fetch_pc_d = fq.redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      // A decoded jump retargets fetch instead of issuing the fall-through pc.
      if (jump_hit) begin
        fetch_pc_d = {5'b0, fq.q_imem[26:0]};
      end else if (issue) begin
        inflight_d = 1'b1;
        tag_d      = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage is data-only; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      entry_pc_q[tail_q]    <= tag_q;
      entry_instr_q[tail_q] <= fq.q_imem;
    end
  end

  assign fq.address_imem = fetch_pc_q;
  assign fq.out_valid    = valid;
  assign fq.out_pc       = valid ? entry_pc_q[head_q]    : 32'd0;
  assign fq.out_instr    = valid ? entry_instr_q[head_q] : 32'd0;
  assign fq.count        = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for backpressure/redirect/wrap plus
// hand sequences for streaming, jump predecode and asynchronous mid-run reset.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic jump_mode = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   got;
  logic [31:0] pd_exp [8];

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [17];

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clock (clock),
    .reset (reset),
    .fq    (bus.master)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (jump_mode && a == 32'd5) return 32'h0800_0040;
    return 32'hA000_0000 | a;
  endfunction

  initial bus.q_imem = 32'd0;
  always @(posedge clock) bus.q_imem <= imem_word(bus.address_imem);

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] ecnt, input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_count = ecnt; v.exp_addr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // rdy, redir, rpc, valid, pc, count, addr (after the edge)
    vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h1);
    vecs[1]  = mk(0, 0, 32'h0,         1, 32'h0,         1, 32'h2);
    vecs[2]  = mk(0, 0, 32'h0,         1, 32'h0,         2, 32'h3);
    vecs[3]  = mk(0, 0, 32'h0,         1, 32'h0,         3, 32'h4);
    vecs[4]  = mk(0, 0, 32'h0,         1, 32'h0,         4, 32'h4);
    vecs[5]  = mk(0, 0, 32'h0,         1, 32'h0,         4, 32'h4);
    vecs[6]  = mk(1, 0, 32'h0,         1, 32'h1,         3, 32'h5);
    vecs[7]  = mk(0, 1, 32'h100,       0, 32'h0,         0, 32'h100);
    vecs[8]  = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h101);
    vecs[9]  = mk(1, 0, 32'h0,         1, 32'h100,       1, 32'h102);
    vecs[10] = mk(1, 0, 32'h0,         1, 32'h101,       1, 32'h103);
    vecs[11] = mk(1, 1, 32'hFFFF_FFFE, 0, 32'h0,         0, 32'hFFFF_FFFE);
    vecs[12] = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFF);
    vecs[13] = mk(1, 0, 32'h0,         1, 32'hFFFF_FFFE, 1, 32'h0);
    vecs[14] = mk(1, 0, 32'h0,         1, 32'hFFFF_FFFF, 1, 32'h1);
    vecs[15] = mk(1, 0, 32'h0,         1, 32'h0,         1, 32'h2);
    vecs[16] = mk(1, 0, 32'h0,         1, 32'h1,         1, 32'h3);

`ifdef FETCHQ_JUMP_PREDECODE_EN
    pd_exp = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h40, 32'h41};
`else
    pd_exp = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
`endif

    bus.out_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;

    // Reset state
    #1 reset = 1'b0;
    #2;
    check("reset_addr",  bus.address_imem, 32'h0);
    check("reset_valid", bus.out_valid, 32'h0);
    check("reset_pc",    bus.out_pc, 32'h0);
    check("reset_instr", bus.out_instr, 32'h0);
    check("reset_count", bus.count, 32'h0);

    // Streaming with out_ready held high
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) begin
        check("stream_valid_c0", bus.out_valid, 32'h0);
        check("stream_addr_c0",  bus.address_imem, 32'h1);
      end else begin
        check("stream_valid", bus.out_valid, 32'h1);
        check("stream_pc",    bus.out_pc, k - 1);
        check("stream_instr", bus.out_instr, 32'hA000_0000 | (k - 1));
        check("stream_count", bus.count, 32'h1);
        check("stream_addr",  bus.address_imem, k + 1);
      end
    end

    // Backpressure, pop-while-full, redirect with fetch in flight, pc wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.out_ready   = vecs[i].rdy;
      bus.redirect    = vecs[i].redir;
      bus.redirect_pc = vecs[i].rpc;
      step();
      check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
      check($sformatf("vec%0d_addr", i),  bus.address_imem, vecs[i].exp_addr);
      check($sformatf("vec%0d_instr", i), bus.out_instr,
            vecs[i].exp_valid ? (32'hA000_0000 | vecs[i].exp_pc) : 32'h0);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].exp_pc);
    end
    bus.redirect = 1'b0;

    // Jump predecode: pc 5 holds j 0x40
    do_reset();
    jump_mode = 1'b1;
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      step();
      if (bus.out_valid) begin
        check($sformatf("pd_pc%0d", got), bus.out_pc, pd_exp[got]);
        if (bus.out_pc == 32'd5)
          check("pd_jump_instr", bus.out_instr, 32'h0800_0040);
        got++;
      end
    end
    if (got < 8) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pd_timeout: got %0d entries expected 8", got);
    end
    jump_mode = 1'b0;

    // Asynchronous reset while full
    do_reset();
    bus.out_ready = 1'b0;
    repeat (6) step();
    check("full_count", bus.count, 32'h4);
    check("full_addr",  bus.address_imem, 32'h4);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 32'h0);
    check("midrst_count", bus.count, 32'h0);
    check("midrst_addr",  bus.address_imem, 32'h0);
    check("midrst_pc",    bus.out_pc, 32'h0);
    check("midrst_instr", bus.out_instr, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("restart_addr",  bus.address_imem, 32'h1);
    check("restart_valid", bus.out_valid, 32'h0);
    step();
    check("restart_valid2", bus.out_valid, 32'h1);
    check("restart_pc",     bus.out_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
